// File: rtl/branch_predictor_bht.sv
// ============================================================================
// Module   : branch_predictor_bht
// Brief    : Direct-mapped saturating-counter BHT with tagged BTB, mispredict
//            detection and saturating branch statistics.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_bht #(
    parameter int unsigned IDX_BITS   = 6,
    parameter int unsigned TAG_BITS   = 8,
    parameter int unsigned CNT_WIDTH  = 2,
    parameter int unsigned INIT_CNT   = 1,
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic [31:0]           lookup_pc,
    output logic                  pred_hit,
    output logic                  pred_taken,
    output logic [31:0]           pred_target,
    input  logic                  upd_valid,
    input  logic [31:0]           upd_pc,
    input  logic                  upd_taken,
    input  logic [31:0]           upd_target,
    input  logic                  upd_pred_taken,
    input  logic [31:0]           upd_pred_target,
    input  logic                  clear,
    output logic                  mispredict,
    output logic [31:0]           redirect_pc,
    output logic [STAT_WIDTH-1:0] stat_branches,
    output logic [STAT_WIDTH-1:0] stat_mispredicts
);

    localparam int unsigned          ENTRIES  = 1 << IDX_BITS;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(INIT_CNT);
    localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

    logic [ENTRIES-1:0]  valid_q, valid_d;
    logic [TAG_BITS-1:0] tag_q [ENTRIES];
    logic [TAG_BITS-1:0] tag_d [ENTRIES];
    logic [CNT_WIDTH-1:0] cnt_q [ENTRIES];
    logic [CNT_WIDTH-1:0] cnt_d [ENTRIES];
    logic [31:0]         tgt_q [ENTRIES];
    logic [31:0]         tgt_d [ENTRIES];
    logic [STAT_WIDTH-1:0] stat_br_q, stat_br_d;
    logic [STAT_WIDTH-1:0] stat_mp_q, stat_mp_d;

    logic [IDX_BITS-1:0] w_lk_idx, w_up_idx;
    logic [TAG_BITS-1:0] w_lk_tag, w_up_tag;
    logic                w_up_hit;

    assign w_lk_idx = lookup_pc[IDX_BITS+1:2];
    assign w_lk_tag = lookup_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_up_idx = upd_pc[IDX_BITS+1:2];
    assign w_up_tag = upd_pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign w_up_hit = valid_q[w_up_idx] && (tag_q[w_up_idx] == w_up_tag);

    // Lookup reads registered state only, so same-cycle training is not bypassed.
    always_comb begin
        pred_hit    = valid_q[w_lk_idx] && (tag_q[w_lk_idx] == w_lk_tag);
        pred_taken  = pred_hit && cnt_q[w_lk_idx][CNT_WIDTH-1];
        pred_target = pred_taken ? tgt_q[w_lk_idx] : lookup_pc + 32'd4;
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        if (clear) begin
            valid_d = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_d[i] = CNT_INIT;
            end
        end else if (upd_valid) begin
            if (w_up_hit) begin
                if (upd_taken) begin
                    if (cnt_q[w_up_idx] != CNT_MAX) begin
                        cnt_d[w_up_idx] = cnt_q[w_up_idx] + CNT_WIDTH'(1);
                    end
                    tgt_d[w_up_idx] = upd_target;
                end else if (cnt_q[w_up_idx] != '0) begin
                    cnt_d[w_up_idx] = cnt_q[w_up_idx] - CNT_WIDTH'(1);
                end
            end else if (upd_taken) begin
                valid_d[w_up_idx] = 1'b1;
                tag_d[w_up_idx]   = w_up_tag;
                cnt_d[w_up_idx]   = CNT_WEAK;
                tgt_d[w_up_idx]   = upd_target;
            end
        end
    end

    // Statistics ignore clear and stick at all-ones.
    always_comb begin
        stat_br_d = stat_br_q;
        stat_mp_d = stat_mp_q;
        if (upd_valid && (stat_br_q != STAT_MAX)) begin
            stat_br_d = stat_br_q + STAT_WIDTH'(1);
        end
        if (mispredict && (stat_mp_q != STAT_MAX)) begin
            stat_mp_d = stat_mp_q + STAT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q   <= '0;
            stat_br_q <= '0;
            stat_mp_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i] <= '0;
                cnt_q[i] <= CNT_INIT;
                tgt_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            tag_q     <= tag_d;
            cnt_q     <= cnt_d;
            tgt_q     <= tgt_d;
            stat_br_q <= stat_br_d;
            stat_mp_q <= stat_mp_d;
        end
    end

    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mp_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_predictor_bht.sv
// ============================================================================
// Module   : tb_branch_predictor_bht
// Brief    : Self-checking bench for branch_predictor_bht against a table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor_bht;

    localparam int N      = 64;
    localparam int IDXB   = 6;
    localparam int NTAG   = 256;
    localparam int CMAX   = 3;
    localparam int CWEAK  = 2;
    localparam int INITC  = 1;
    localparam longint SMALL_MAX = 15;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] lookup_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        clear;

    logic        pred_hit, pred_taken, mispredict;
    logic [31:0] pred_target, redirect_pc, stat_branches, stat_mispredicts;
    logic        s_hit, s_taken, s_mp;
    logic [31:0] s_target, s_redirect;
    logic [3:0]  s_br, s_mpc;

    always #5 clk = ~clk;

    branch_predictor_bht u_dut (
        .clk(clk), .rstn(rstn), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .clear(clear),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
    );

    branch_predictor_bht #(.STAT_WIDTH(4)) u_small (
        .clk(clk), .rstn(rstn), .lookup_pc(lookup_pc),
        .pred_hit(s_hit), .pred_taken(s_taken), .pred_target(s_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .clear(clear),
        .mispredict(s_mp), .redirect_pc(s_redirect),
        .stat_branches(s_br), .stat_mispredicts(s_mpc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one record per table slot, plain integer counters.
    bit          m_valid [N];
    int          m_tag   [N];
    int          m_cnt   [N];
    logic [31:0] m_tgt   [N];
    longint      m_br, m_mp;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % N);
    endfunction

    function automatic int tag_of(input logic [31:0] pc);
        return int'((pc >> (2 + IDXB)) % NTAG);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    function automatic bit m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[idx_of(pc)] >= CWEAK);
    endfunction

    function automatic bit m_mispredict();
        return upd_valid && ((upd_taken != upd_pred_taken) ||
                             (upd_taken && (upd_target != upd_pred_target)));
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N; i++) begin
                m_valid[i] <= 1'b0;
                m_tag[i]   <= 0;
                m_cnt[i]   <= INITC;
                m_tgt[i]   <= 32'h0;
            end
            m_br <= 0;
            m_mp <= 0;
        end else begin
            if (clear) begin
                for (int i = 0; i < N; i++) begin
                    m_valid[i] <= 1'b0;
                    m_cnt[i]   <= INITC;
                end
            end else if (upd_valid) begin
                if (m_hit(upd_pc)) begin
                    if (upd_taken) begin
                        m_cnt[idx_of(upd_pc)] <= (m_cnt[idx_of(upd_pc)] + 1 > CMAX) ? CMAX : m_cnt[idx_of(upd_pc)] + 1;
                        m_tgt[idx_of(upd_pc)] <= upd_target;
                    end else begin
                        m_cnt[idx_of(upd_pc)] <= (m_cnt[idx_of(upd_pc)] - 1 < 0) ? 0 : m_cnt[idx_of(upd_pc)] - 1;
                    end
                end else if (upd_taken) begin
                    m_valid[idx_of(upd_pc)] <= 1'b1;
                    m_tag[idx_of(upd_pc)]   <= tag_of(upd_pc);
                    m_cnt[idx_of(upd_pc)]   <= CWEAK;
                    m_tgt[idx_of(upd_pc)]   <= upd_target;
                end
            end
            m_br <= m_br + (upd_valid ? 1 : 0);
            m_mp <= m_mp + (m_mispredict() ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        chk("pred_hit", {31'b0, pred_hit}, {31'b0, m_hit(lookup_pc)});
        chk("pred_taken", {31'b0, pred_taken}, {31'b0, m_taken(lookup_pc)});
        chk("pred_target", pred_target,
            m_taken(lookup_pc) ? m_tgt[idx_of(lookup_pc)] : lookup_pc + 32'd4);
        chk("mispredict", {31'b0, mispredict}, {31'b0, m_mispredict()});
        chk("redirect_pc", redirect_pc, upd_taken ? upd_target : upd_pc + 32'd4);
        chk("stat_branches", stat_branches, 32'(m_br));
        chk("stat_mispredicts", stat_mispredicts, 32'(m_mp));
        chk("small_pred_hit", {31'b0, s_hit}, {31'b0, m_hit(lookup_pc)});
        chk("small_stat_branches", {28'b0, s_br}, 32'(sat(m_br, SMALL_MAX)));
        chk("small_stat_mispredicts", {28'b0, s_mpc}, 32'(sat(m_mp, SMALL_MAX)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic idle();
        upd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0; clear = 1'b0; lookup_pc = 32'h0040_0010;
        upd(32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        idle();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        #1;
        // Reset state
        chk("t1_hit", {31'b0, pred_hit}, 32'd0);
        chk("t1_taken", {31'b0, pred_taken}, 32'd0);
        chk("t1_target", pred_target, 32'h0040_0014);
        chk("t1_stat_br", stat_branches, 32'd0);
        chk("t1_stat_mp", stat_mispredicts, 32'd0);

        // First taken branch allocates weakly taken
        upd(32'h0040_0010, 1'b1, 32'h0040_0000, 1'b0, 32'h0040_0014);
        #1;
        chk("t2_mp", {31'b0, mispredict}, 32'd1);
        chk("t2_redirect", redirect_pc, 32'h0040_0000);
        tick(); idle(); #1;
        chk("t2_hit", {31'b0, pred_hit}, 32'd1);
        chk("t2_taken", {31'b0, pred_taken}, 32'd1);
        chk("t2_target", pred_target, 32'h0040_0000);
        chk("t2_stat_br", stat_branches, 32'd1);
        chk("t2_stat_mp", stat_mispredicts, 32'd1);

        // Saturate up, then walk down to weakly not-taken
        repeat (3) begin
            upd(32'h0040_0010, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000);
            #1 chk("t3_mp_taken", {31'b0, mispredict}, 32'd0);
            tick();
        end
        repeat (2) begin
            upd(32'h0040_0010, 1'b0, 32'h0040_0000, 1'b1, 32'h0040_0000);
            #1;
            chk("t3_mp_nt", {31'b0, mispredict}, 32'd1);
            chk("t3_redirect", redirect_pc, 32'h0040_0014);
            tick();
        end
        idle(); #1;
        chk("t3_hit", {31'b0, pred_hit}, 32'd1);
        chk("t3_taken", {31'b0, pred_taken}, 32'd0);
        chk("t3_target", pred_target, 32'h0040_0014);

        // Alias on index 4 with a different tag
        lookup_pc = 32'h0040_0110; #1;
        chk("t4_hit", {31'b0, pred_hit}, 32'd0);
        chk("t4_target", pred_target, 32'h0040_0114);
        upd(32'h0040_0110, 1'b0, 32'h0, 1'b0, 32'h0040_0114);
        #1 chk("t4_mp", {31'b0, mispredict}, 32'd0);
        tick(); idle(); lookup_pc = 32'h0040_0010; #1;
        chk("t4_entry_hit", {31'b0, pred_hit}, 32'd1);
        chk("t4_entry_taken", {31'b0, pred_taken}, 32'd0);

        // Same-cycle lookup and train: no bypass
        upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b0, 32'h0040_0014);
        #1;
        chk("t5_old_taken", {31'b0, pred_taken}, 32'd0);
        chk("t5_old_target", pred_target, 32'h0040_0014);
        tick(); idle(); #1;
        chk("t5_new_taken", {31'b0, pred_taken}, 32'd1);
        chk("t5_new_target", pred_target, 32'h0040_0040);
        upd(32'h0040_0020, 1'b1, 32'h0040_0100, 1'b1, 32'h0040_0100);
        tick();
        clear = 1'b1;
        upd(32'h0040_0010, 1'b1, 32'h0040_0040, 1'b1, 32'h0040_0040);
        tick();
        clear = 1'b0; idle(); #1;
        chk("t5_clear_hit", {31'b0, pred_hit}, 32'd0);
        chk("t5_stat_br", stat_branches, 32'd10);
        chk("t5_stat_mp", stat_mispredicts, 32'd4);
        lookup_pc = 32'h0040_0020; #1;
        chk("t5_clear_hit2", {31'b0, pred_hit}, 32'd0);

        // Mid-cycle asynchronous reset
        lookup_pc = 32'h0040_0010;
        upd(32'h0040_0010, 1'b1, 32'h0040_0000, 1'b0, 32'h0040_0014);
        tick(); idle(); #1;
        chk("t6_pre_hit", {31'b0, pred_hit}, 32'd1);
        rstn = 1'b0; #1;
        chk("t6_rst_hit", {31'b0, pred_hit}, 32'd0);
        chk("t6_rst_br", stat_branches, 32'd0);
        chk("t6_rst_mp", stat_mispredicts, 32'd0);
        tick(); rstn = 1'b1;

        // Every update mispredicts: small build saturates at 0xF
        for (int i = 0; i < 17; i++) begin
            logic tk;
            tk = (i % 3) != 0;
            upd(32'h0040_0000 + 32'(i % 4) * 32'd4, tk, 32'h0040_0800 + 32'(i) * 32'd16,
                ~tk, 32'h0040_0000);
            tick();
        end
        idle(); #1;
        chk("t6_small_mp_sat", {28'b0, s_mpc}, 32'h0000_000F);
        chk("t6_small_br_sat", {28'b0, s_br}, 32'h0000_000F);
        chk("t6_big_mp", stat_mispredicts, 32'd17);
        upd(32'h0040_0004, 1'b0, 32'h0, 1'b1, 32'h0);
        tick(); idle(); #1;
        chk("t6_small_mp_hold", {28'b0, s_mpc}, 32'h0000_000F);
        chk("t6_big_mp2", stat_mispredicts, 32'd18);

        @(negedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/branch_predictor_bht.md
Name: branch_predictor_bht

Overview:
Parametrised branch prediction unit for the 5-stage PCPU. It is the next generation of the single global 2-bit predictor in the hazard/forwarding unit. It provides a direct-mapped table of N-bit saturating counters plus a tagged branch target buffer (BTB), looked up in IF and trained by branch resolution in ID. It also produces the mispredict/redirect signals that the hazard unit uses to flush IF/ID, and running statistics counters.

Parameters:
IDX_BITS, 6, table index width; table has 2**IDX_BITS entries
TAG_BITS, 8, tag width stored per entry; IDX_BITS+TAG_BITS <= 30
CNT_WIDTH, 2, saturating counter width (>=1)
INIT_CNT, 1, counter value after reset/clear (< 2**CNT_WIDTH)
STAT_WIDTH, 32, width of statistics counters

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
lookup_pc  in  32  PC of instruction being fetched (IF)
pred_hit  out  1  valid entry with matching tag for lookup_pc
pred_taken  out  1  predicted direction for lookup_pc
pred_target  out  32  predicted next PC for lookup_pc
upd_valid  in  1  a branch resolved in ID this cycle (not stalled)
upd_pc  in  32  PC of resolved branch
upd_taken  in  1  actual direction
upd_target  in  32  actual taken target
upd_pred_taken  in  1  direction that was predicted for this branch in IF
upd_pred_target  in  32  pred_target that was used in IF
clear  in  1  synchronous invalidate of whole table
mispredict  out  1  resolved branch disagrees with its prediction
redirect_pc  out  32  correct next PC when mispredict=1
stat_branches  out  STAT_WIDTH  count of upd_valid cycles
stat_mispredicts  out  STAT_WIDTH  count of mispredict cycles

Behaviour:
- Index = pc[IDX_BITS+1:2]. Tag = pc[IDX_BITS+TAG_BITS+1:IDX_BITS+2]. Per entry: valid, tag, cnt[CNT_WIDTH-1:0], target[31:0].
- rstn low (async): all valid=0, all cnt=INIT_CNT, targets=0, stat counters=0. Table storage is registers (no RAM macro), so the clear is immediate.
- Lookup (combinational, 0 latency): pred_hit = valid[idx] && tag[idx]==tag(lookup_pc). pred_taken = pred_hit && cnt[idx][CNT_WIDTH-1]. pred_target = pred_taken ? target[idx] : lookup_pc+4 (32-bit wrap).
- Mispredict (combinational): mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)). redirect_pc = upd_taken ? upd_target : upd_pc+4. redirect_pc is don't-care-free: it is always driven by this formula.
- Training on rising edge when upd_valid=1 and clear=0:
  - Hit (valid and tag match): taken → cnt = min(cnt+1, 2**CNT_WIDTH-1), target=upd_target. Not taken → cnt = max(cnt-1, 0), target unchanged.
  - Miss and taken: allocate/replace; valid=1, tag=tag(upd_pc), target=upd_target, cnt=2**(CNT_WIDTH-1) (weakly taken).
  - Miss and not taken: no table change.
- clear=1: next edge sets all valid=0 and all cnt=INIT_CNT. clear has priority over a simultaneous update. Stat counters are unaffected by clear.
- Same-cycle lookup and update of the same entry: lookup returns pre-update contents (no bypass). The new value is visible the next cycle.
- Stats: on each edge, stat_branches += upd_valid and stat_mispredicts += mispredict. Both saturate at all-ones and never wrap.
- Reset asserted mid-operation: the table and stats clear immediately. Outputs reflect the empty table while rstn is low.

Test Plan:
Defaults apply (IDX_BITS=6, CNT_WIDTH=2, INIT_CNT=1).
1. Reset, lookup_pc=0x00400010 → pred_hit=0, pred_taken=0, pred_target=0x00400014; stats=0.
2. upd pc=0x00400010, taken=1, target=0x00400000, pred_taken=0 → same cycle mispredict=1, redirect_pc=0x00400000. Next cycle lookup of 0x00400010 → hit=1, pred_taken=1 (cnt=2), pred_target=0x00400000; stat_branches=1, stat_mispredicts=1.
3. Three more correctly predicted taken updates → cnt saturates at 3, mispredict=0. Then two not-taken updates with pred_taken=1 → mispredict=1 each, redirect=0x00400014, cnt=1, pred_taken=0, hit stays 1.
4. Alias check: lookup 0x00400110 (same index 4, different tag) → pred_hit=0, pred_target=0x00400114. A not-taken update on it with pred_taken=0 → mispredict=0 and entry 4 is unchanged.
5. Same-cycle lookup and training update on entry 4 → lookup shows the old cnt/target; the next cycle shows the new values. Also assert clear and upd_valid together → all entries invalid next cycle, stats still increment.
6. Deassert rstn mid-stream with stats non-zero → pred_hit=0 and stats=0 immediately. Force stat_mispredicts to all-ones (STAT_WIDTH=4 build) plus one more mispredict → holds at 0xF.
